alu_exec_wb: RTL and testbench
==============================

// Module: alu_exec_wb
// PURPOSE
//  Execute/writeback stage downstream of the register bank. Captures busA/busB operands
//  and an opcode, computes the result (single-cycle ops or iterative multiply), then drives
//  busC/busCsel and a one-cycle WriteC pulse back into the register bank. busC is held
//  stable for a full cycle before WriteC rises, because the bank writes on the WriteC edge.
// PARAMETERS
//  DATA_W  32  operand/result width
//  SEL_W   5   register select width (32 registers)
// PORTS
//  clk       in   1       single clock, rising edge
//  reset     in   1       asynchronous, active-high
//  start     in   1       request; accepted only at a clk edge with ready=1
//  op        in   4       opcode, sampled with start
//  busA      in   DATA_W  operand A, sampled with start
//  busB      in   DATA_W  operand B, sampled with start
//  dst_sel   in   SEL_W   destination register, sampled with start
//  ready     out  1       1 = IDLE, can accept start
//  busC      out  DATA_W  result to register bank
//  busCsel   out  SEL_W   destination select to register bank
//  WriteC    out  1       write strobe to register bank, one-cycle pulse
//  flag_z    out  1       result == 0
//  flag_c    out  1       carry out (ADD), NOT borrow (SUB); 0 otherwise
//  flag_v    out  1       signed overflow (ADD/SUB); 0 otherwise
//  illegal   out  1       last accepted op was unsupported
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE; ready=1; busC, busCsel, WriteC, all flags, illegal = 0.
//  FSM: IDLE -start-> EXEC | MUL; EXEC -> WB; MUL (32 iterations) -> WB; WB -> STROBE; STROBE -> IDLE.
//  Accept edge N: latch op, busA, busB, dst_sel; ready=0.
//  Edge N+1 (EXEC): busC, busCsel, flags registered; state=WB; WriteC=0.
//  Edge N+2 (WB): WriteC=1 if dst_sel!=0 and op is legal; busC/busCsel unchanged.
//  Edge N+3 (STROBE): WriteC=0; ready=1. busC, busCsel, flags hold until the next result.
//  Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (shift amount = busB[4:0] LSBs),
//   8 SLT (signed, result 0/1), 9 SLTU (result 0/1), A PASSB, B MUL (low DATA_W bits of A*B).
//  All arithmetic is modulo 2^DATA_W.
//  Illegal op (C-F): busC=0, illegal=1, WriteC never pulses; timing is identical to a legal op.
//  illegal is cleared by the next legal op.
//  dst_sel=0: full timing runs, WriteC stays 0.
//  start while ready=0: ignored; no queuing.
//  Reset mid-operation: return to IDLE immediately; no WriteC pulse is emitted.
// CONFIGURATION
//  ALU_EXEC_MUL_EN defined: op B uses an iterative shift-add multiplier.
//   - State MUL runs 32 cycles; result is registered on the 32nd MUL edge; then WB, then STROBE.
//   - ready returns 34 cycles after the accept edge.
//   - flag_c=flag_v=0; flag_z reflects the result.
//  ALU_EXEC_MUL_EN undefined: no multiplier logic; op B is treated as illegal (busC=0, illegal=1, no write).
// TESTING
//  ADD A=0x7FFFFFFF B=1 dst=3 -> busC=0x80000000, v=1, c=0; WriteC high exactly on cycle N+2; ready on N+3.
//  SUB A=5 B=5 dst=4 -> busC=0, z=1, c=1; SRA A=0x80000000 B=4 -> busC=0xF8000000.
//  SLT A=0xFFFFFFFF B=1 -> busC=1; SLTU with same operands -> busC=0; dst=0 -> WriteC never asserts.
//  MUL A=0x10001 B=0x10001 with ALU_EXEC_MUL_EN -> busC=0x00020001 after 32 MUL cycles;
//   without the macro -> illegal=1, no WriteC.
//  start asserted again during EXEC/WB -> ignored; exactly one WriteC pulse per accepted op.
//  reset asserted in EXEC or MUL -> all outputs 0 the same cycle; no WriteC pulse; ready=1.

Source files
------------

// File: rtl/alu_exec_wb.sv
// Execute/writeback stage: latches operands, computes a result, then strobes WriteC into the register bank.
// Optional iterative multiplier for op B when ALU_EXEC_MUL_EN is defined; otherwise op B is illegal.
module alu_exec_wb #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  input  logic [SEL_W-1:0]  dst_sel,
  output logic              ready,
  output logic [DATA_W-1:0] busC,
  output logic [SEL_W-1:0]  busCsel,
  output logic              WriteC,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic              illegal
);
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  typedef enum logic [2:0] {IDLE, EXEC, MUL, WB, STROBE} state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  dst;
  } req_t;

  state_t state, stateNext;
  req_t   req;
  logic   accept;

  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] aluRes;
  logic              aluC, aluV, aluIll;
  logic [SH_W-1:0]   shamt;

`ifdef ALU_EXEC_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);
  logic [DATA_W-1:0] mulAcc, mulMcand, mulMplier, mulSum;
  logic [CNT_W-1:0]  mulCnt;
  logic              mulLast;

  assign mulSum  = mulAcc + (mulMplier[0] ? mulMcand : '0);
  assign mulLast = (mulCnt == CNT_W'(DATA_W - 1));
`endif

  assign ready  = (state == IDLE);
  assign accept = start && ready;

  assign sum   = {1'b0, req.a} + {1'b0, req.b};
  assign diff  = {1'b0, req.a} - {1'b0, req.b};
  assign shamt = req.b[SH_W-1:0];

  always_comb begin
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    aluIll = 1'b0;
    case (req.op)
      4'h0: begin
        aluRes = sum[MSB:0];
        aluC   = sum[DATA_W];
        aluV   = (req.a[MSB] == req.b[MSB]) && (sum[MSB] != req.a[MSB]);
      end
      4'h1: begin
        aluRes = diff[MSB:0];
        aluC   = ~diff[DATA_W];  // carry = NOT borrow
        aluV   = (req.a[MSB] != req.b[MSB]) && (diff[MSB] != req.a[MSB]);
      end
      4'h2: aluRes = req.a & req.b;
      4'h3: aluRes = req.a | req.b;
      4'h4: aluRes = req.a ^ req.b;
      4'h5: aluRes = req.a << shamt;
      4'h6: aluRes = req.a >> shamt;
      4'h7: aluRes = $signed(req.a) >>> shamt;
      4'h8: aluRes = {{(DATA_W-1){1'b0}}, $signed(req.a) < $signed(req.b)};
      4'h9: aluRes = {{(DATA_W-1){1'b0}}, req.a < req.b};
      4'hA: aluRes = req.b;
      default: aluIll = 1'b1;  // includes B: multiplies never pass through EXEC
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef ALU_EXEC_MUL_EN
          stateNext = (op == 4'hB) ? MUL : EXEC;
`else
          stateNext = EXEC;
`endif
        end
      end
      EXEC:    stateNext = WB;
`ifdef ALU_EXEC_MUL_EN
      MUL:     if (mulLast) stateNext = WB;
`endif
      WB:      stateNext = STROBE;
      STROBE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req     <= '0;
      busC    <= '0;
      busCsel <= '0;
      WriteC  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mulAcc    <= '0;
      mulMcand  <= '0;
      mulMplier <= '0;
      mulCnt    <= '0;
`endif
    end else begin
      if (accept) begin
        req <= '{op: op, a: busA, b: busB, dst: dst_sel};
`ifdef ALU_EXEC_MUL_EN
        mulAcc    <= '0;
        mulMcand  <= busA;
        mulMplier <= busB;
        mulCnt    <= '0;
`endif
      end
      case (state)
        EXEC: begin
          busC    <= aluRes;
          busCsel <= req.dst;
          flag_z  <= (aluRes == '0);
          flag_c  <= aluC;
          flag_v  <= aluV;
          illegal <= aluIll;
        end
`ifdef ALU_EXEC_MUL_EN
        MUL: begin
          // shift-add: one multiplier bit per cycle, LSB first
          mulAcc    <= mulSum;
          mulMcand  <= mulMcand << 1;
          mulMplier <= mulMplier >> 1;
          mulCnt    <= mulCnt + 1'b1;
          if (mulLast) begin
            busC    <= mulSum;
            busCsel <= req.dst;
            flag_z  <= (mulSum == '0);
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            illegal <= 1'b0;
          end
        end
`endif
        WB:      WriteC <= (req.dst != '0) && !illegal;
        STROBE:  WriteC <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_wb.sv
// Scoreboard bench for alu_exec_wb: expected results queued at issue, compared when ready returns.
module tb_alu_exec_wb;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] busA, busB;
  logic [4:0]  dst_sel;
  logic        ready;
  logic [31:0] busC;
  logic [4:0]  busCsel;
  logic        WriteC, flag_z, flag_c, flag_v, illegal;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  sel;
    logic        wr, z, c, v, ill;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  alu_exec_wb #(.DATA_W(32), .SEL_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .busA(busA), .busB(busB),
    .dst_sel(dst_sel), .ready(ready), .busC(busC), .busCsel(busCsel), .WriteC(WriteC),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] d);
    exp_t e;
    logic [32:0] s33;
    longint sl;
    e.res = '0; e.c = 1'b0; e.v = 1'b0; e.ill = 1'b0; e.lat = 3;
    case (o)
      4'h0: begin
        s33 = {1'b0, a} + {1'b0, b};
        e.res = s33[31:0];
        e.c = s33[32];
        sl = longint'($signed(a)) + longint'($signed(b));
        e.v = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
      end
      4'h1: begin
        e.res = a - b;
        e.c = (a >= b);
        sl = longint'($signed(a)) - longint'($signed(b));
        e.v = (sl > 64'sd2147483647) || (sl < -64'sd2147483648);
      end
      4'h2: e.res = a & b;
      4'h3: e.res = a | b;
      4'h4: e.res = a ^ b;
      4'h5: e.res = a << b[4:0];
      4'h6: e.res = a >> b[4:0];
      4'h7: e.res = $signed(a) >>> b[4:0];
      4'h8: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h9: e.res = (a < b) ? 32'd1 : 32'd0;
      4'hA: e.res = b;
`ifdef ALU_EXEC_MUL_EN
      4'hB: begin e.res = a * b; e.lat = 34; end
`endif
      default: e.ill = 1'b1;
    endcase
    if (e.ill) e.res = '0;
    e.z = (e.res == 32'd0);
    e.sel = d;
    e.wr = !e.ill && (d != 5'd0);
    return e;
  endfunction

  // Issue one op; optionally keep start high (with different operands) during EXEC/WB.
  task automatic runOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input bit hammer);
    exp_t e;
    int pulses, wcyc, rcyc;
    @(negedge clk);
    start = 1'b1; op = o; busA = a; busB = b; dst_sel = d;
    sbq.push_back(model(o, a, b, d));
    @(posedge clk); #1;
    chk("ready_drop", {31'd0, ready}, 32'd0);
    if (hammer) begin op = 4'h0; busA = 32'h1234; busB = 32'h1; dst_sel = 5'd31; end
    else start = 1'b0;
    pulses = 0; wcyc = -1; rcyc = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (WriteC) begin pulses++; wcyc = cyc; end
      if (cyc == 2) start = 1'b0;
      if (ready) begin rcyc = cyc; break; end
    end
    e = sbq.pop_front();
    chk("ready_lat", rcyc, e.lat);
    chk("wr_pulses", pulses, {31'd0, e.wr});
    if (e.wr) chk("wr_cycle", wcyc, e.lat - 1);
    chk("wr_low_at_ready", {31'd0, WriteC}, 32'd0);
    chk("busC", busC, e.res);
    chk("busCsel", {27'd0, busCsel}, {27'd0, e.sel});
    chk("flags_zcv", {29'd0, flag_z, flag_c, flag_v}, {29'd0, e.z, e.c, e.v});
    chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
  endtask

  // Reset after `waitCyc` cycles of a busy op: outputs clear at once, no strobe follows.
  task automatic resetMid(input logic [3:0] o, input int waitCyc);
    int pulses;
    @(negedge clk);
    start = 1'b1; op = o; busA = 32'h10001; busB = 32'h10001; dst_sel = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (waitCyc) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_busC", busC, 32'd0);
    chk("rst_outs", {26'd0, busCsel, WriteC}, 32'd0);
    chk("rst_flags", {28'd0, flag_z, flag_c, flag_v, illegal}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    @(negedge clk); reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (WriteC) pulses++;
    end
    chk("rst_no_wr", pulses, 32'd0);
    chk("rst_ready_after", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; busA = '0; busB = '0; dst_sel = '0;
    #12;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_busC", busC, 32'd0);
    chk("reset_outs", {26'd0, busCsel, WriteC}, 32'd0);
    chk("reset_flags", {28'd0, flag_z, flag_c, flag_v, illegal}, 32'd0);
    @(negedge clk); reset = 1'b0;

    runOp(4'h0, 32'h7FFFFFFF, 32'h1, 5'd3, 1'b0);
    runOp(4'h1, 32'd5, 32'd5, 5'd4, 1'b0);
    runOp(4'h7, 32'h80000000, 32'd4, 5'd5, 1'b0);
    runOp(4'h8, 32'hFFFFFFFF, 32'd1, 5'd6, 1'b0);
    runOp(4'h9, 32'hFFFFFFFF, 32'd1, 5'd7, 1'b0);
    runOp(4'h0, 32'hFFFFFFFF, 32'd1, 5'd0, 1'b0);
    runOp(4'h1, 32'd0, 32'd1, 5'd8, 1'b0);
    runOp(4'h1, 32'h80000000, 32'd1, 5'd9, 1'b0);
    runOp(4'h2, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd10, 1'b0);
    runOp(4'h3, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd11, 1'b0);
    runOp(4'h4, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd12, 1'b0);
    runOp(4'h5, 32'h0000_00F1, 32'hFFFF_FFE7, 5'd13, 1'b0);
    runOp(4'h6, 32'h8000_0F00, 32'd31, 5'd14, 1'b0);
    runOp(4'hA, 32'h1, 32'hCAFE_BABE, 5'd15, 1'b0);
    runOp(4'hD, 32'h5, 32'h6, 5'd16, 1'b0);
    runOp(4'h0, 32'h5, 32'h6, 5'd17, 1'b0);
    runOp(4'hB, 32'h10001, 32'h10001, 5'd18, 1'b0);
    runOp(4'h0, 32'h1111, 32'h2222, 5'd19, 1'b1);
    runOp(4'h9, 32'd3, 32'd9, 5'd20, 1'b1);

    for (int i = 0; i < 12; i++)
      runOp(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b0);

    resetMid(4'h0, 0);
`ifdef ALU_EXEC_MUL_EN
    resetMid(4'hB, 10);
`endif
    runOp(4'h1, 32'd10, 32'd3, 5'd21, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
